// File: rtl/ccip_afu_port_mux_pkg.sv
// rtl/ccip_afu_port_mux_pkg.sv - shared widths, request types and round-robin arbiter for the port mux
package ccip_afu_port_mux_pkg;

  localparam int MAX_PORTS   = 8;
  localparam int REQ_ADDR_W  = 42;
  localparam int REQ_DATA_W  = 512;
  localparam int REQ_MDATA_W = 14;

  function automatic int port_idx_w(input int n_ports);
    return (n_ports <= 2) ? 1 : $clog2(n_ports);
  endfunction

  typedef logic [$clog2(MAX_PORTS)-1:0] t_port_idx;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0]  addr;
    logic [REQ_MDATA_W-1:0] mdata;
  } t_c0_req;

  typedef struct packed {
    logic [REQ_ADDR_W-1:0]  addr;
    logic [REQ_DATA_W-1:0]  data;
    logic [REQ_MDATA_W-1:0] mdata;
  } t_c1_req;

  typedef struct packed {
    logic      valid;
    t_port_idx idx;
  } t_grant;

  // First requesting port at or after ptr, wrapping at n_ports.
  function automatic t_grant rr_arbitrate(input logic [MAX_PORTS-1:0] req,
                                          input t_port_idx ptr, input int n_ports);
    t_grant    g;
    t_port_idx cand;
    g = '0;
    for (int i = 0; i < MAX_PORTS; i++) begin
      cand = t_port_idx'((int'(ptr) + i) % n_ports);
      if (i < n_ports && !g.valid && req[cand]) begin
        g.valid = 1'b1;
        g.idx   = cand;
      end
    end
    return g;
  endfunction

  function automatic t_port_idx rr_next(input t_port_idx idx, input int n_ports);
    return (int'(idx) == n_ports - 1) ? '0 : idx + 1'b1;
  endfunction

endpackage

// File: rtl/ccip_afu_port_mux_fifo.sv
// rtl/ccip_afu_port_mux_fifo.sv - per-port request FIFO with registered almost-full flag
module ccip_afu_port_mux_fifo #(
  parameter int WIDTH         = 8,
  parameter int DEPTH         = 8,
  parameter int ALMFULL_SLACK = 2
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic             empty,
  output logic             almfull
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_V = (AW+1)'(DEPTH);
  localparam logic [AW:0] SLACK_V = (AW+1)'(ALMFULL_SLACK);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             almfull_q, almfull_d;
  logic             full, do_push, do_pop;

  assign full    = (count_q == DEPTH_V);
  assign empty   = (count_q == '0);
  assign do_pop  = pop && !empty;
  // Pop is resolved first so a full FIFO still accepts a push in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign head    = mem_q[rd_ptr_q];
  assign almfull = almfull_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    almfull_d = ((DEPTH_V - count_d) <= SLACK_V);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      almfull_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      almfull_q <= almfull_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!reset_n)
                                 !(push && full && !do_pop));

endmodule

// File: rtl/ccip_afu_port_mux.sv
// rtl/ccip_afu_port_mux.sv - N-way CCI-P request mux with round-robin arbitration and mdata-routed Rx
// Optional per-port grant counters: define AFU_PORT_MUX_STATS_EN.
module ccip_afu_port_mux
  import ccip_afu_port_mux_pkg::*;
#(
  parameter int N_PORTS       = 4,
  parameter int ADDR_W        = 42,
  parameter int DATA_W        = 512,
  parameter int MDATA_W       = 14,
  parameter int FIFO_DEPTH    = 8,
  parameter int ALMFULL_SLACK = 2,
  localparam int PW           = port_idx_w(N_PORTS)
) (
  input  logic                      clk,
  input  logic                      reset_n,
`ifdef AFU_PORT_MUX_STATS_EN
  output logic [N_PORTS*32-1:0]     stat_c0_cnt,
  output logic [N_PORTS*32-1:0]     stat_c1_cnt,
`endif
  input  logic [N_PORTS-1:0]        app_c0_valid,
  input  logic [N_PORTS*ADDR_W-1:0] app_c0_addr,
  input  logic [N_PORTS*MDATA_W-1:0] app_c0_mdata,
  input  logic [N_PORTS-1:0]        app_c1_valid,
  input  logic [N_PORTS*ADDR_W-1:0] app_c1_addr,
  input  logic [N_PORTS*DATA_W-1:0] app_c1_data,
  input  logic [N_PORTS*MDATA_W-1:0] app_c1_mdata,
  output logic [N_PORTS-1:0]        app_c0_almfull,
  output logic [N_PORTS-1:0]        app_c1_almfull,
  output logic                      fiu_c0_valid,
  output logic [ADDR_W-1:0]         fiu_c0_addr,
  output logic [MDATA_W+PW-1:0]     fiu_c0_mdata,
  output logic                      fiu_c1_valid,
  output logic [ADDR_W-1:0]         fiu_c1_addr,
  output logic [DATA_W-1:0]         fiu_c1_data,
  output logic [MDATA_W+PW-1:0]     fiu_c1_mdata,
  input  logic                      fiu_c0_almfull,
  input  logic                      fiu_c1_almfull,
  input  logic                      fiu_rx_c0_valid,
  input  logic [MDATA_W+PW-1:0]     fiu_rx_c0_mdata,
  input  logic [DATA_W-1:0]         fiu_rx_c0_data,
  input  logic                      fiu_rx_c1_valid,
  input  logic [MDATA_W+PW-1:0]     fiu_rx_c1_mdata,
  output logic [N_PORTS-1:0]        app_rx_c0_valid,
  output logic [N_PORTS-1:0]        app_rx_c1_valid,
  output logic [DATA_W-1:0]         app_rx_c0_data,
  output logic [MDATA_W-1:0]        app_rx_c0_mdata,
  output logic [MDATA_W-1:0]        app_rx_c1_mdata
);

  // Request structs are sized by the package, so the port widths must agree with it.
  if (ADDR_W != REQ_ADDR_W || DATA_W != REQ_DATA_W || MDATA_W != REQ_MDATA_W ||
      N_PORTS < 2 || N_PORTS > MAX_PORTS) begin : g_bad_cfg
    $error("ccip_afu_port_mux: unsupported parameter set");
  end

  t_c0_req              c0_in   [N_PORTS];
  t_c0_req              c0_head [N_PORTS];
  t_c1_req              c1_in   [N_PORTS];
  t_c1_req              c1_head [N_PORTS];
  logic [N_PORTS-1:0]   c0_empty, c1_empty, c0_pop, c1_pop;
  logic [MAX_PORTS-1:0] c0_req, c1_req;
  t_grant               c0_grant, c1_grant;
  t_port_idx            c0_rr_q, c0_rr_d, c1_rr_q, c1_rr_d;
  t_c0_req              c0_sel;
  t_c1_req              c1_sel;

  logic                  fiu_c0_valid_q, fiu_c0_valid_d, fiu_c1_valid_q, fiu_c1_valid_d;
  logic [ADDR_W-1:0]     fiu_c0_addr_q, fiu_c0_addr_d, fiu_c1_addr_q, fiu_c1_addr_d;
  logic [DATA_W-1:0]     fiu_c1_data_q, fiu_c1_data_d;
  logic [MDATA_W+PW-1:0] fiu_c0_mdata_q, fiu_c0_mdata_d, fiu_c1_mdata_q, fiu_c1_mdata_d;

  logic [PW-1:0]         rx_c0_idx, rx_c1_idx;
  logic [N_PORTS-1:0]    rx_c0_valid_q, rx_c0_valid_d, rx_c1_valid_q, rx_c1_valid_d;
  logic [DATA_W-1:0]     rx_c0_data_q;
  logic [MDATA_W-1:0]    rx_c0_mdata_q, rx_c1_mdata_q;

  for (genvar p = 0; p < N_PORTS; p++) begin : g_port
    assign c0_in[p] = t_c0_req'{addr:  app_c0_addr[p*ADDR_W +: ADDR_W],
                                mdata: app_c0_mdata[p*MDATA_W +: MDATA_W]};
    assign c1_in[p] = t_c1_req'{addr:  app_c1_addr[p*ADDR_W +: ADDR_W],
                                data:  app_c1_data[p*DATA_W +: DATA_W],
                                mdata: app_c1_mdata[p*MDATA_W +: MDATA_W]};

    ccip_afu_port_mux_fifo #(
      .WIDTH($bits(t_c0_req)), .DEPTH(FIFO_DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK)
    ) u_c0_fifo (
      .clk(clk), .reset_n(reset_n), .push(app_c0_valid[p]), .push_data(c0_in[p]),
      .pop(c0_pop[p]), .head(c0_head[p]), .empty(c0_empty[p]), .almfull(app_c0_almfull[p])
    );

    ccip_afu_port_mux_fifo #(
      .WIDTH($bits(t_c1_req)), .DEPTH(FIFO_DEPTH), .ALMFULL_SLACK(ALMFULL_SLACK)
    ) u_c1_fifo (
      .clk(clk), .reset_n(reset_n), .push(app_c1_valid[p]), .push_data(c1_in[p]),
      .pop(c1_pop[p]), .head(c1_head[p]), .empty(c1_empty[p]), .almfull(app_c1_almfull[p])
    );
  end

  always_comb begin
    c0_req                = '0;
    c1_req                = '0;
    c0_req[N_PORTS-1:0]   = ~c0_empty;
    c1_req[N_PORTS-1:0]   = ~c1_empty;
    c0_grant              = '0;
    c1_grant              = '0;
    if (!fiu_c0_almfull) c0_grant = rr_arbitrate(c0_req, c0_rr_q, N_PORTS);
    if (!fiu_c1_almfull) c1_grant = rr_arbitrate(c1_req, c1_rr_q, N_PORTS);
    c0_rr_d = c0_grant.valid ? rr_next(c0_grant.idx, N_PORTS) : c0_rr_q;
    c1_rr_d = c1_grant.valid ? rr_next(c1_grant.idx, N_PORTS) : c1_rr_q;
    c0_pop  = '0;
    c1_pop  = '0;
    c0_sel  = '0;
    c1_sel  = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (c0_grant.valid && c0_grant.idx == t_port_idx'(p)) begin
        c0_pop[p] = 1'b1;
        c0_sel    = c0_head[p];
      end
      if (c1_grant.valid && c1_grant.idx == t_port_idx'(p)) begin
        c1_pop[p] = 1'b1;
        c1_sel    = c1_head[p];
      end
    end
    fiu_c0_valid_d = c0_grant.valid;
    fiu_c0_addr_d  = c0_sel.addr;
    fiu_c0_mdata_d = {c0_grant.idx[PW-1:0], c0_sel.mdata};
    fiu_c1_valid_d = c1_grant.valid;
    fiu_c1_addr_d  = c1_sel.addr;
    fiu_c1_data_d  = c1_sel.data;
    fiu_c1_mdata_d = {c1_grant.idx[PW-1:0], c1_sel.mdata};
  end

  assign rx_c0_idx = fiu_rx_c0_mdata[MDATA_W +: PW];
  assign rx_c1_idx = fiu_rx_c1_mdata[MDATA_W +: PW];

  always_comb begin
    rx_c0_valid_d = '0;
    rx_c1_valid_d = '0;
    for (int p = 0; p < N_PORTS; p++) begin
      if (fiu_rx_c0_valid && rx_c0_idx == PW'(p)) rx_c0_valid_d[p] = 1'b1;
      if (fiu_rx_c1_valid && rx_c1_idx == PW'(p)) rx_c1_valid_d[p] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      c0_rr_q        <= '0;
      c1_rr_q        <= '0;
      fiu_c0_valid_q <= 1'b0;
      fiu_c1_valid_q <= 1'b0;
      rx_c0_valid_q  <= '0;
      rx_c1_valid_q  <= '0;
    end else begin
      c0_rr_q        <= c0_rr_d;
      c1_rr_q        <= c1_rr_d;
      fiu_c0_valid_q <= fiu_c0_valid_d;
      fiu_c1_valid_q <= fiu_c1_valid_d;
      rx_c0_valid_q  <= rx_c0_valid_d;
      rx_c1_valid_q  <= rx_c1_valid_d;
    end
  end

  // Payload registers are qualified by the valids and need no reset.
  always_ff @(posedge clk) begin
    fiu_c0_addr_q  <= fiu_c0_addr_d;
    fiu_c0_mdata_q <= fiu_c0_mdata_d;
    fiu_c1_addr_q  <= fiu_c1_addr_d;
    fiu_c1_data_q  <= fiu_c1_data_d;
    fiu_c1_mdata_q <= fiu_c1_mdata_d;
    rx_c0_data_q   <= fiu_rx_c0_data;
    rx_c0_mdata_q  <= fiu_rx_c0_mdata[MDATA_W-1:0];
    rx_c1_mdata_q  <= fiu_rx_c1_mdata[MDATA_W-1:0];
  end

  assign fiu_c0_valid    = fiu_c0_valid_q;
  assign fiu_c0_addr     = fiu_c0_addr_q;
  assign fiu_c0_mdata    = fiu_c0_mdata_q;
  assign fiu_c1_valid    = fiu_c1_valid_q;
  assign fiu_c1_addr     = fiu_c1_addr_q;
  assign fiu_c1_data     = fiu_c1_data_q;
  assign fiu_c1_mdata    = fiu_c1_mdata_q;
  assign app_rx_c0_valid = rx_c0_valid_q;
  assign app_rx_c1_valid = rx_c1_valid_q;
  assign app_rx_c0_data  = rx_c0_data_q;
  assign app_rx_c0_mdata = rx_c0_mdata_q;
  assign app_rx_c1_mdata = rx_c1_mdata_q;

  rx_c0_idx_chk: assert property (@(posedge clk) disable iff (!reset_n)
                                  fiu_rx_c0_valid |-> ({1'b0, rx_c0_idx} < (PW+1)'(N_PORTS)));
  rx_c1_idx_chk: assert property (@(posedge clk) disable iff (!reset_n)
                                  fiu_rx_c1_valid |-> ({1'b0, rx_c1_idx} < (PW+1)'(N_PORTS)));

`ifdef AFU_PORT_MUX_STATS_EN
  logic [31:0] stat_c0_q [N_PORTS];
  logic [31:0] stat_c0_d [N_PORTS];
  logic [31:0] stat_c1_q [N_PORTS];
  logic [31:0] stat_c1_d [N_PORTS];

  always_comb begin
    for (int p = 0; p < N_PORTS; p++) begin
      stat_c0_d[p] = stat_c0_q[p];
      stat_c1_d[p] = stat_c1_q[p];
      if (c0_pop[p] && stat_c0_q[p] != '1) stat_c0_d[p] = stat_c0_q[p] + 32'd1;
      if (c1_pop[p] && stat_c1_q[p] != '1) stat_c1_d[p] = stat_c1_q[p] + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int p = 0; p < N_PORTS; p++) begin
        stat_c0_q[p] <= '0;
        stat_c1_q[p] <= '0;
      end
    end else begin
      for (int p = 0; p < N_PORTS; p++) begin
        stat_c0_q[p] <= stat_c0_d[p];
        stat_c1_q[p] <= stat_c1_d[p];
      end
    end
  end

  for (genvar p = 0; p < N_PORTS; p++) begin : g_stat
    assign stat_c0_cnt[p*32 +: 32] = stat_c0_q[p];
    assign stat_c1_cnt[p*32 +: 32] = stat_c1_q[p];
  end
`endif

endmodule

// File: tb/tb_ccip_afu_port_mux.sv
// tb/tb_ccip_afu_port_mux.sv - self-checking bench for ccip_afu_port_mux with queue-based reference model
module tb_ccip_afu_port_mux;

  localparam int N = 4, AW = 42, DW = 512, MW = 14, PW = 2, DEPTH = 8, SLACK = 2;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [N-1:0]      app_c0_valid, app_c1_valid, app_c0_almfull, app_c1_almfull;
  logic [N*AW-1:0]   app_c0_addr, app_c1_addr;
  logic [N*MW-1:0]   app_c0_mdata, app_c1_mdata;
  logic [N*DW-1:0]   app_c1_data;
  logic              fiu_c0_valid, fiu_c1_valid, fiu_c0_almfull, fiu_c1_almfull;
  logic [AW-1:0]     fiu_c0_addr, fiu_c1_addr;
  logic [MW+PW-1:0]  fiu_c0_mdata, fiu_c1_mdata, fiu_rx_c0_mdata, fiu_rx_c1_mdata;
  logic [DW-1:0]     fiu_c1_data, fiu_rx_c0_data, app_rx_c0_data;
  logic              fiu_rx_c0_valid, fiu_rx_c1_valid;
  logic [N-1:0]      app_rx_c0_valid, app_rx_c1_valid;
  logic [MW-1:0]     app_rx_c0_mdata, app_rx_c1_mdata;
`ifdef AFU_PORT_MUX_STATS_EN
  logic [N*32-1:0]   stat_c0_cnt, stat_c1_cnt;
  int                st0 [N];
  int                st1 [N];
`endif

  ccip_afu_port_mux dut (
    .clk(clk), .reset_n(reset_n),
`ifdef AFU_PORT_MUX_STATS_EN
    .stat_c0_cnt(stat_c0_cnt), .stat_c1_cnt(stat_c1_cnt),
`endif
    .app_c0_valid(app_c0_valid), .app_c0_addr(app_c0_addr), .app_c0_mdata(app_c0_mdata),
    .app_c1_valid(app_c1_valid), .app_c1_addr(app_c1_addr), .app_c1_data(app_c1_data),
    .app_c1_mdata(app_c1_mdata), .app_c0_almfull(app_c0_almfull), .app_c1_almfull(app_c1_almfull),
    .fiu_c0_valid(fiu_c0_valid), .fiu_c0_addr(fiu_c0_addr), .fiu_c0_mdata(fiu_c0_mdata),
    .fiu_c1_valid(fiu_c1_valid), .fiu_c1_addr(fiu_c1_addr), .fiu_c1_data(fiu_c1_data),
    .fiu_c1_mdata(fiu_c1_mdata), .fiu_c0_almfull(fiu_c0_almfull), .fiu_c1_almfull(fiu_c1_almfull),
    .fiu_rx_c0_valid(fiu_rx_c0_valid), .fiu_rx_c0_mdata(fiu_rx_c0_mdata),
    .fiu_rx_c0_data(fiu_rx_c0_data), .fiu_rx_c1_valid(fiu_rx_c1_valid),
    .fiu_rx_c1_mdata(fiu_rx_c1_mdata), .app_rx_c0_valid(app_rx_c0_valid),
    .app_rx_c1_valid(app_rx_c1_valid), .app_rx_c0_data(app_rx_c0_data),
    .app_rx_c0_mdata(app_rx_c0_mdata), .app_rx_c1_mdata(app_rx_c1_mdata)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [MW-1:0] mdata;
  } req_t;

  req_t mq0[N][$];
  req_t mq1[N][$];
  int   rr0, rr1;
  int   n_cmp = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] rnd_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW/32; i++) r[i*32 +: 32] = $urandom();
    return r;
  endfunction

  function automatic int pick(input int ch);
    int ptr;
    ptr = (ch == 0) ? rr0 : rr1;
    for (int i = 0; i < N; i++) begin
      int p;
      p = (ptr + i) % N;
      if (ch == 0 && mq0[p].size() > 0) return p;
      if (ch == 1 && mq1[p].size() > 0) return p;
    end
    return -1;
  endfunction

  task automatic clear_inputs();
    app_c0_valid = '0; app_c1_valid = '0;
    fiu_c0_almfull = 1'b0; fiu_c1_almfull = 1'b0;
    fiu_rx_c0_valid = 1'b0; fiu_rx_c1_valid = 1'b0;
  endtask

  task automatic model_reset();
    for (int p = 0; p < N; p++) begin
      mq0[p].delete();
      mq1[p].delete();
`ifdef AFU_PORT_MUX_STATS_EN
      st0[p] = 0;
      st1[p] = 0;
`endif
    end
    rr0 = 0;
    rr1 = 0;
  endtask

  // One clock: model consumes the applied inputs, then every output is compared after the edge.
  task automatic step();
    int g0, g1;
    req_t e0, e1;
    logic [N-1:0] erx0, erx1;
    logic [DW-1:0] ed0;
    logic [MW-1:0] em0, em1;
    logic [MW+PW-1:0] fm;
    g0 = fiu_c0_almfull ? -1 : pick(0);
    g1 = fiu_c1_almfull ? -1 : pick(1);
    if (g0 >= 0) begin e0 = mq0[g0].pop_front(); rr0 = (g0 + 1) % N; end
    if (g1 >= 0) begin e1 = mq1[g1].pop_front(); rr1 = (g1 + 1) % N; end
`ifdef AFU_PORT_MUX_STATS_EN
    if (g0 >= 0) st0[g0]++;
    if (g1 >= 0) st1[g1]++;
`endif
    for (int p = 0; p < N; p++) begin
      if (app_c0_valid[p])
        mq0[p].push_back('{addr: app_c0_addr[p*AW +: AW], data: '0, mdata: app_c0_mdata[p*MW +: MW]});
      if (app_c1_valid[p])
        mq1[p].push_back('{addr: app_c1_addr[p*AW +: AW], data: app_c1_data[p*DW +: DW],
                           mdata: app_c1_mdata[p*MW +: MW]});
    end
    erx0 = '0; erx1 = '0;
    if (fiu_rx_c0_valid) erx0[fiu_rx_c0_mdata[MW +: PW]] = 1'b1;
    if (fiu_rx_c1_valid) erx1[fiu_rx_c1_mdata[MW +: PW]] = 1'b1;
    ed0 = fiu_rx_c0_data;
    em0 = fiu_rx_c0_mdata[MW-1:0];
    em1 = fiu_rx_c1_mdata[MW-1:0];
    @(posedge clk);
    #1;
    chk("fiu_c0_valid", fiu_c0_valid, g0 >= 0);
    if (g0 >= 0) begin
      fm = {g0[PW-1:0], e0.mdata};
      chk("fiu_c0_addr", fiu_c0_addr, e0.addr);
      chk("fiu_c0_mdata", fiu_c0_mdata, fm);
    end
    chk("fiu_c1_valid", fiu_c1_valid, g1 >= 0);
    if (g1 >= 0) begin
      fm = {g1[PW-1:0], e1.mdata};
      chk("fiu_c1_addr", fiu_c1_addr, e1.addr);
      chk("fiu_c1_data", fiu_c1_data, e1.data);
      chk("fiu_c1_mdata", fiu_c1_mdata, fm);
    end
    for (int p = 0; p < N; p++) begin
      chk("c0_almfull", app_c0_almfull[p], (DEPTH - mq0[p].size()) <= SLACK);
      chk("c1_almfull", app_c1_almfull[p], (DEPTH - mq1[p].size()) <= SLACK);
    end
    chk("rx_c0_valid", app_rx_c0_valid, erx0);
    chk("rx_c1_valid", app_rx_c1_valid, erx1);
    if (erx0 != '0) begin
      chk("rx_c0_data", app_rx_c0_data, ed0);
      chk("rx_c0_mdata", app_rx_c0_mdata, em0);
    end
    if (erx1 != '0) chk("rx_c1_mdata", app_rx_c1_mdata, em1);
  endtask

  typedef struct {
    logic             v0;
    logic [MW+PW-1:0] m0;
    logic [31:0]      d0;
    logic             v1;
    logic [MW+PW-1:0] m1;
    logic [N-1:0]     exp0;
    logic [N-1:0]     exp1;
    logic [MW-1:0]    expm0;
    logic [MW-1:0]    expm1;
  } rx_vec_t;

  initial begin
    rx_vec_t tv[6];
    int g0, g1;
    tv[0] = '{1'b1, {2'd3, 14'h002A}, 32'hDEAD, 1'b0, 16'h0,             4'b1000, 4'b0000, 14'h002A, 14'h0};
    tv[1] = '{1'b1, {2'd0, 14'h3FFF}, 32'h1,    1'b1, {2'd0, 14'h0011},  4'b0001, 4'b0001, 14'h3FFF, 14'h0011};
    tv[2] = '{1'b0, {2'd2, 14'h0001}, 32'h2,    1'b1, {2'd2, 14'h0000},  4'b0000, 4'b0100, 14'h0,    14'h0000};
    tv[3] = '{1'b1, {2'd1, 14'h0155}, 32'hBEEF, 1'b1, {2'd3, 14'h2AAA},  4'b0010, 4'b1000, 14'h0155, 14'h2AAA};
    tv[4] = '{1'b0, {2'd1, 14'h0007}, 32'h5,    1'b0, {2'd1, 14'h0007},  4'b0000, 4'b0000, 14'h0,    14'h0};
    tv[5] = '{1'b1, {2'd2, 14'h1234}, 32'hCAFE, 1'b0, {2'd0, 14'h0}, 4'b0100, 4'b0000, 14'h1234, 14'h0};

    clear_inputs();
    app_c0_addr = '0; app_c1_addr = '0; app_c0_mdata = '0; app_c1_mdata = '0; app_c1_data = '0;
    fiu_rx_c0_mdata = '0; fiu_rx_c1_mdata = '0; fiu_rx_c0_data = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_fiu_c0_valid", fiu_c0_valid, 1'b0);
    chk("rst_fiu_c1_valid", fiu_c1_valid, 1'b0);
    chk("rst_rx_valid", {app_rx_c0_valid, app_rx_c1_valid}, '0);
    chk("rst_almfull", {app_c0_almfull, app_c1_almfull}, '0);
    reset_n = 1'b1;

    // Port 2 reads 0x100/0x101 back to back.
    app_c0_valid[2] = 1'b1; app_c0_addr[2*AW +: AW] = 42'h100; app_c0_mdata[2*MW +: MW] = 14'd5;
    step();
    chk("t1_lat", fiu_c0_valid, 1'b0);
    app_c0_addr[2*AW +: AW] = 42'h101; app_c0_mdata[2*MW +: MW] = 14'd6;
    step();
    chk("t1_v0", fiu_c0_valid, 1'b1);
    chk("t1_a0", fiu_c0_addr, 42'h100);
    chk("t1_m0", fiu_c0_mdata, 16'h8005);
    clear_inputs();
    step();
    chk("t1_a1", fiu_c0_addr, 42'h101);
    chk("t1_m1", fiu_c0_mdata, 16'h8006);
    step();
    chk("t1_idle", fiu_c0_valid, 1'b0);

    // All four ports write together: FIU order 0,1,2,3, pointer wraps to 0.
    for (int p = 0; p < N; p++) begin
      app_c1_valid[p] = 1'b1;
      app_c1_addr[p*AW +: AW] = 42'h200 + p;
      app_c1_mdata[p*MW +: MW] = 14'h10 + p;
      app_c1_data[p*DW +: DW] = rnd_data();
    end
    step();
    clear_inputs();
    for (int p = 0; p < N; p++) begin
      step();
      chk("t2_valid", fiu_c1_valid, 1'b1);
      chk("t2_port", fiu_c1_mdata[MW +: PW], p);
    end
    app_c1_valid[3] = 1'b1; app_c1_valid[0] = 1'b1;
    step();
    clear_inputs();
    step();
    chk("t2_rr_wrap", fiu_c1_mdata[MW +: PW], 2'd0);
    step();
    chk("t2_rr_next", fiu_c1_mdata[MW +: PW], 2'd3);

    // FIU backpressure while port 1 fills its write FIFO.
    fiu_c1_almfull = 1'b1;
    for (int i = 0; i < 20; i++) begin
      app_c1_valid[1] = (i < 6);
      app_c1_addr[1*AW +: AW] = 42'h300 + i;
      app_c1_mdata[1*MW +: MW] = MW'(i);
      step();
      chk("t3_hold", fiu_c1_valid, 1'b0);
      if (i == 4) chk("t3_almfull_5", app_c1_almfull[1], 1'b0);
      if (i == 5) chk("t3_almfull_6", app_c1_almfull[1], 1'b1);
    end
    clear_inputs();
    for (int k = 0; k < 6; k++) begin
      step();
      chk("t3_drain_v", fiu_c1_valid, 1'b1);
      chk("t3_drain_m", fiu_c1_mdata, 16'h4000 | k);
    end
    step();
    chk("t3_drained", fiu_c1_valid, 1'b0);

    // Rx routing vectors.
    for (int i = 0; i < 6; i++) begin
      fiu_rx_c0_valid = tv[i].v0; fiu_rx_c0_mdata = tv[i].m0; fiu_rx_c0_data = DW'(tv[i].d0);
      fiu_rx_c1_valid = tv[i].v1; fiu_rx_c1_mdata = tv[i].m1;
      step();
      chk("tv_rx0_valid", app_rx_c0_valid, tv[i].exp0);
      chk("tv_rx1_valid", app_rx_c1_valid, tv[i].exp1);
      if (tv[i].v0) begin
        chk("tv_rx0_mdata", app_rx_c0_mdata, tv[i].expm0);
        chk("tv_rx0_data", app_rx_c0_data, DW'(tv[i].d0));
      end
      if (tv[i].v1) chk("tv_rx1_mdata", app_rx_c1_mdata, tv[i].expm1);
    end
    clear_inputs();

    // Reset while port 0 holds three queued reads and an Rx response is in flight.
    fiu_c0_almfull = 1'b1;
    for (int i = 0; i < 3; i++) begin
      app_c0_valid[0] = 1'b1; app_c0_addr[0 +: AW] = 42'h400 + i;
      fiu_rx_c0_valid = (i == 2); fiu_rx_c0_mdata = {2'd1, 14'h0};
      step();
    end
    clear_inputs();
    fiu_c0_almfull = 1'b1;
    reset_n = 1'b0;
    #2;
    chk("t5_fiu_valid", {fiu_c0_valid, fiu_c1_valid}, 2'b00);
    chk("t5_rx_valid", {app_rx_c0_valid, app_rx_c1_valid}, '0);
    chk("t5_almfull", {app_c0_almfull, app_c1_almfull}, '0);
    model_reset();
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    fiu_c0_almfull = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t5_no_stale", fiu_c0_valid, 1'b0);
    end

    // Randomized traffic including full+pop pushes.
    for (int c = 0; c < 600; c++) begin
      fiu_c0_almfull = ($urandom_range(0, 3) == 0);
      fiu_c1_almfull = ($urandom_range(0, 3) == 0);
      g0 = fiu_c0_almfull ? -1 : pick(0);
      g1 = fiu_c1_almfull ? -1 : pick(1);
      for (int p = 0; p < N; p++) begin
        app_c0_valid[p] = ($urandom_range(0, 99) < 45) && (mq0[p].size() < DEPTH || g0 == p);
        app_c1_valid[p] = ($urandom_range(0, 99) < 45) && (mq1[p].size() < DEPTH || g1 == p);
        app_c0_addr[p*AW +: AW] = {$urandom(), $urandom()};
        app_c1_addr[p*AW +: AW] = {$urandom(), $urandom()};
        app_c0_mdata[p*MW +: MW] = MW'($urandom());
        app_c1_mdata[p*MW +: MW] = MW'($urandom());
        app_c1_data[p*DW +: DW] = rnd_data();
      end
      fiu_rx_c0_valid = $urandom_range(0, 1);
      fiu_rx_c1_valid = $urandom_range(0, 1);
      fiu_rx_c0_mdata = {PW'($urandom_range(0, N-1)), MW'($urandom())};
      fiu_rx_c1_mdata = {PW'($urandom_range(0, N-1)), MW'($urandom())};
      fiu_rx_c0_data = rnd_data();
      step();
    end
    clear_inputs();
    repeat (2*N*DEPTH + 4) step();
    for (int p = 0; p < N; p++) begin
      chk("drain_c0_empty", mq0[p].size(), 0);
      chk("drain_c1_empty", mq1[p].size(), 0);
    end

`ifdef AFU_PORT_MUX_STATS_EN
    model_reset();
    reset_n = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      app_c0_valid[1] = 1'b1;
      step();
    end
    clear_inputs();
    repeat (4) step();
    for (int p = 0; p < N; p++) begin
      chk("stat_c0", stat_c0_cnt[p*32 +: 32], (p == 1) ? 32'd10 : 32'd0);
      chk("stat_c1", stat_c1_cnt[p*32 +: 32], 32'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/ccip_afu_port_mux.md
Name: ccip_afu_port_mux

Overview:
- Parametrised N-way multiplexer between several application engines and a single CCI-P/MPF request path.
- Generalises the current single-app wiring so multiple `app_afu` instances can share one MPF instance.
- Each port has its own request FIFOs per Tx channel, with fair round-robin arbitration toward the FIU side.
- The port index is carried in the upper mdata bits, so Rx responses are routed back to the issuing port.

Parameters:
- N_PORTS, 4, number of application ports (2..8).
- ADDR_W, 42, line address width.
- DATA_W, 512, line data width.
- MDATA_W, 14, mdata bits owned by each application port.
- FIFO_DEPTH, 8, per-port per-channel request FIFO depth (power of 2, ≥4).
- ALMFULL_SLACK, 2, free entries at or below which a port's almost-full is asserted.

Ports:
Clock and reset:
- clk  in  1  single clock for all logic.
- reset_n  in  1  asynchronous, active-low reset.

Application side (Tx requests in, per port):
- app_c0_valid  in  N_PORTS  read request valid, per port.
- app_c0_addr  in  N_PORTS*ADDR_W  read address.
- app_c0_mdata  in  N_PORTS*MDATA_W  read mdata.
- app_c1_valid  in  N_PORTS  write request valid.
- app_c1_addr  in  N_PORTS*ADDR_W  write address.
- app_c1_data  in  N_PORTS*DATA_W  write data.
- app_c1_mdata  in  N_PORTS*MDATA_W  write mdata.
- app_c0_almfull  out  N_PORTS  per-port c0 backpressure.
- app_c1_almfull  out  N_PORTS  per-port c1 backpressure.

FIU side (Tx requests out):
- fiu_c0_valid  out  1  merged read request valid.
- fiu_c0_addr  out  ADDR_W  merged read address.
- fiu_c0_mdata  out  MDATA_W+PW  {port index, app mdata}; PW = clog2(N_PORTS).
- fiu_c1_valid  out  1  merged write request valid.
- fiu_c1_addr  out  ADDR_W  merged write address.
- fiu_c1_data  out  DATA_W  merged write data.
- fiu_c1_mdata  out  MDATA_W+PW  {port index, app mdata}.
- fiu_c0_almfull  in  1  FIU read backpressure.
- fiu_c1_almfull  in  1  FIU write backpressure.

FIU side (Rx responses in):
- fiu_rx_c0_valid  in  1  read response valid.
- fiu_rx_c0_mdata  in  MDATA_W+PW  read response mdata.
- fiu_rx_c0_data  in  DATA_W  read response data.
- fiu_rx_c1_valid  in  1  write response valid.
- fiu_rx_c1_mdata  in  MDATA_W+PW  write response mdata.

Application side (Rx responses out):
- app_rx_c0_valid  out  N_PORTS  one-hot read response valid.
- app_rx_c1_valid  out  N_PORTS  one-hot write response valid.
- app_rx_c0_data  out  DATA_W  broadcast read data.
- app_rx_c0_mdata  out  MDATA_W  broadcast read mdata, port bits stripped.
- app_rx_c1_mdata  out  MDATA_W  broadcast write mdata, port bits stripped.

Behaviour:
- Reset: all valids 0, all FIFOs empty, both arbiter pointers at port 0.
  - app_*_almfull reset to 0.
  - Data/addr/mdata registers are don't-care.
  - Reset asserted mid-operation drops all queued requests, with no partial output.
- Enqueue: app_cX_valid pushes into that port's channel FIFO the same cycle.
  - A push while the FIFO is full is a protocol error. The push is dropped, the occupancy count does not wrap, and a simulation assertion fires.
- app_cX_almfull[p] is registered and equals (free entries ≤ ALMFULL_SLACK), updated one cycle after the occupancy change.
- Arbitration runs independently per channel, every cycle that fiu_cX_almfull==0.
  - Grant goes to the first non-empty port at or after rr_ptr, wrapping from N_PORTS-1 to 0.
  - The granted head is popped, and rr_ptr becomes grant+1 mod N_PORTS.
  - No grant is made while fiu_cX_almfull==1; FIFOs hold.
  - With all FIFOs empty, rr_ptr is unchanged.
- Output is registered: fiu_cX_valid is asserted the cycle after the grant. Minimum app→FIU latency is 2 cycles (enqueue cycle + output register).
- fiu_cX_mdata = {grant index (PW bits), app mdata}.
- Rx routing is a single register stage:
  - app_rx_cX_valid[idx] = fiu_rx_cX_valid, where idx = fiu_rx_cX_mdata[MDATA_W+PW-1:MDATA_W].
  - An idx ≥ N_PORTS drives no valid and fires an assertion.
- Simultaneous c0 and c1 activity, and simultaneous Rx c0/c1 to the same port, are fully independent.
- Enqueue and pop on the same FIFO in the same cycle leaves occupancy unchanged. This is legal when the FIFO is full, but only if the pop is decided first, so full+pop accepts the push.

Optional Feature:
- AFU_PORT_MUX_STATS_EN adds output ports stat_c0_cnt and stat_c1_cnt (N_PORTS*32 each).
  - Each port counter increments on every grant to that port.
  - Counters saturate at 0xFFFFFFFF and reset to 0.
- Without the macro, these ports and counters do not exist.

Decomposition:
- Package ccip_afu_port_mux_pkg holds:
  - the PW localparam function;
  - the t_port_idx typedef;
  - the c0 request struct {addr, mdata};
  - the c1 request struct {addr, data, mdata}.
- One sub-module, ccip_afu_port_mux_fifo: parametrised width/depth FIFO with a registered almfull output. It is instantiated 2*N_PORTS times.
- The round-robin arbiter is a function in the package.

Test Plan:
- Single port 2 issues reads at 0x100 and 0x101 with mdata 5 and 6 → fiu_c0 valid 2 cycles later with mdata {2,5} then {2,6}, in order.
- All 4 ports issue one write each in the same cycle, rr_ptr=0 → FIU order is ports 0,1,2,3 on consecutive cycles; rr_ptr ends at 0.
- fiu_c1_almfull held high for 20 cycles while port 1 pushes 6 writes → app_c1_almfull[1] rises after the 6th push (free=2); no fiu_c1_valid; on release, 6 writes drain back-to-back.
- Rx c0 with mdata {3,0x2A} and data 0xDEAD → app_rx_c0_valid=4'b1000, mdata 0x2A, data 0xDEAD, 1 cycle later.
- reset_n pulsed low with 3 entries queued in port 0 → all valids 0 immediately; no stale request after release.
- (Stats on) 10 reads from port 1 → stat_c0_cnt[1]=10, others 0.
